// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported synchronous data memory.
// Port 0 has fixed priority; a starvation counter forces port 1 after STARVE_MAX losses.
module dmem_arbiter #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_done,
    output logic          p1_done,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic          busy,
    output logic          CEN,
    output logic          WEN,
    output logic          OEN,
    output logic [AW-1:0] A,
    output logic [DW-1:0] Data2Mem,
    input  logic [DW-1:0] ReadDataMem
);

    localparam int SCW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t           r_state, w_stateNext;
    logic             r_owner, w_ownerNext;
    logic             r_we, w_weNext;
    logic [AW-1:0]    r_addr, w_addrNext;
    logic [DW-1:0]    r_wdata, w_wdataNext;
    logic [2:0]       r_latCnt, w_latCntNext;
    logic [SCW-1:0]   r_starveCnt, w_starveNext;
    logic             r_p0Gnt, r_p1Gnt, r_p0Done, r_p1Done;
    logic             w_p0GntNext, w_p1GntNext, w_p0DoneNext, w_p1DoneNext;
    logic             w_cap0, w_cap1;
    logic [DW-1:0]    r_p0Rdata, r_p1Rdata;
    logic             r_busy;
    logic             r_cen, r_wen, r_oen;
    logic             w_cenNext, w_wenNext, w_oenNext;
    logic             w_p1Win;

    assign w_p1Win = p1_req && (!p0_req || (r_starveCnt == SCW'(STARVE_MAX)));

    // Every strobe and pulse is computed for the coming state so the outputs are pure registers.
    always_comb begin
        w_stateNext  = r_state;
        w_ownerNext  = r_owner;
        w_weNext     = r_we;
        w_addrNext   = r_addr;
        w_wdataNext  = r_wdata;
        w_latCntNext = r_latCnt;
        w_starveNext = r_starveCnt;
        w_p0GntNext  = 1'b0;
        w_p1GntNext  = 1'b0;
        w_p0DoneNext = 1'b0;
        w_p1DoneNext = 1'b0;
        w_cap0       = 1'b0;
        w_cap1       = 1'b0;
        w_cenNext    = 1'b1;
        w_wenNext    = 1'b1;
        w_oenNext    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!p1_req) begin
                    w_starveNext = '0;
                end
                if (p0_req || p1_req) begin
                    w_stateNext = CMD;
                    w_ownerNext = w_p1Win;
                    w_weNext    = w_p1Win ? p1_we    : p0_we;
                    w_addrNext  = w_p1Win ? p1_addr  : p0_addr;
                    w_wdataNext = w_p1Win ? p1_wdata : p0_wdata;
                    w_p0GntNext = !w_p1Win;
                    w_p1GntNext = w_p1Win;
                    w_cenNext   = 1'b0;
                    w_wenNext   = !w_weNext;
                    w_oenNext   = w_weNext;
                    if (w_p1Win) begin
                        w_starveNext = '0;
                    end else if (p1_req && (r_starveCnt != SCW'(STARVE_MAX))) begin
                        w_starveNext = r_starveCnt + 1'b1;
                    end
                end
            end
            CMD: begin
                if (r_we) begin
                    w_stateNext  = IDLE;
                    w_p0DoneNext = !r_owner;
                    w_p1DoneNext = r_owner;
                end else begin
                    w_stateNext  = WAIT;
                    w_latCntNext = '0;
                    w_oenNext    = 1'b0;
                end
            end
            WAIT: begin
                if (r_latCnt == 3'(RD_LAT - 1)) begin
                    w_stateNext  = IDLE;
                    w_p0DoneNext = !r_owner;
                    w_p1DoneNext = r_owner;
                    w_cap0       = !r_owner;
                    w_cap1       = r_owner;
                end else begin
                    w_latCntNext = r_latCnt + 3'd1;
                    w_oenNext    = 1'b0;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Reset abandons any in-flight access and releases the strobes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_latCnt    <= '0;
            r_starveCnt <= '0;
            r_p0Gnt     <= 1'b0;
            r_p1Gnt     <= 1'b0;
            r_p0Done    <= 1'b0;
            r_p1Done    <= 1'b0;
            r_p0Rdata   <= '0;
            r_p1Rdata   <= '0;
            r_busy      <= 1'b0;
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_oen       <= 1'b1;
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_we        <= w_weNext;
            r_addr      <= w_addrNext;
            r_wdata     <= w_wdataNext;
            r_latCnt    <= w_latCntNext;
            r_starveCnt <= w_starveNext;
            r_p0Gnt     <= w_p0GntNext;
            r_p1Gnt     <= w_p1GntNext;
            r_p0Done    <= w_p0DoneNext;
            r_p1Done    <= w_p1DoneNext;
            r_busy      <= (w_stateNext != IDLE);
            r_cen       <= w_cenNext;
            r_wen       <= w_wenNext;
            r_oen       <= w_oenNext;
            if (w_cap0) begin
                r_p0Rdata <= ReadDataMem;
            end
            if (w_cap1) begin
                r_p1Rdata <= ReadDataMem;
            end
        end
    end

    assign p0_gnt   = r_p0Gnt;
    assign p1_gnt   = r_p1Gnt;
    assign p0_done  = r_p0Done;
    assign p1_done  = r_p1Done;
    assign p0_rdata = r_p0Rdata;
    assign p1_rdata = r_p1Rdata;
    assign busy     = r_busy;
    assign CEN      = r_cen;
    assign WEN      = r_wen;
    assign OEN      = r_oen;
    assign A        = r_addr;
    assign Data2Mem = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A (RD_LAT=1, STARVE_MAX=2) with a memory model,
// instance B (RD_LAT=3) with a hand-driven read bus; completions are matched against a scoreboard.
module tb_dmem_arbiter;

    typedef struct {
        bit          port;
        bit          isRead;
        logic [31:0] rdata;
    } sbEntry_t;

    logic clk, rst_n;

    logic        a_p0_req, a_p0_we, a_p1_req, a_p1_we;
    logic [6:0]  a_p0_addr, a_p1_addr, a_A;
    logic [31:0] a_p0_wdata, a_p1_wdata, a_rdm, a_p0_rdata, a_p1_rdata, a_Data2Mem;
    logic        a_p0_gnt, a_p1_gnt, a_p0_done, a_p1_done, a_busy, a_CEN, a_WEN, a_OEN;

    logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [6:0]  b_p0_addr, b_p1_addr, b_A;
    logic [31:0] b_p0_wdata, b_p1_wdata, b_rdm, b_p0_rdata, b_p1_rdata, b_Data2Mem;
    logic        b_p0_gnt, b_p1_gnt, b_p0_done, b_p1_done, b_busy, b_CEN, b_WEN, b_OEN;

    logic [31:0] mem [0:127];
    sbEntry_t    qa[$];
    sbEntry_t    qb[$];
    int          compared;
    int          mismatched;
    bit          found;
    bit          expOrder [0:8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    dmem_arbiter #(.AW(7), .DW(32), .RD_LAT(1), .STARVE_MAX(2)) dutA (
        .clk(clk), .rst_n(rst_n),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p0_gnt(a_p0_gnt), .p1_gnt(a_p1_gnt), .p0_done(a_p0_done), .p1_done(a_p1_done),
        .p0_rdata(a_p0_rdata), .p1_rdata(a_p1_rdata), .busy(a_busy),
        .CEN(a_CEN), .WEN(a_WEN), .OEN(a_OEN), .A(a_A), .Data2Mem(a_Data2Mem),
        .ReadDataMem(a_rdm)
    );

    dmem_arbiter #(.AW(7), .DW(32), .RD_LAT(3), .STARVE_MAX(4)) dutB (
        .clk(clk), .rst_n(rst_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p0_gnt(b_p0_gnt), .p1_gnt(b_p1_gnt), .p0_done(b_p0_done), .p1_done(b_p1_done),
        .p0_rdata(b_p0_rdata), .p1_rdata(b_p1_rdata), .busy(b_busy),
        .CEN(b_CEN), .WEN(b_WEN), .OEN(b_OEN), .A(b_A), .Data2Mem(b_Data2Mem),
        .ReadDataMem(b_rdm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM behind instance A: one-cycle read latency.
    always @(posedge clk) begin
        if (!a_CEN && !a_WEN) mem[a_A] <= a_Data2Mem;
        if (!a_CEN && a_WEN) a_rdm <= mem[a_A];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r0, input bit w0, input logic [6:0] ad0, input logic [31:0] d0,
                                 input bit r1, input bit w1, input logic [6:0] ad1, input logic [31:0] d1);
        a_p0_req = r0; a_p0_we = w0; a_p0_addr = ad0; a_p0_wdata = d0;
        a_p1_req = r1; a_p1_we = w1; a_p1_addr = ad1; a_p1_wdata = d1;
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, " CEN"}, a_CEN, 1);
        checkOutput({tag, " WEN"}, a_WEN, 1);
        checkOutput({tag, " OEN"}, a_OEN, 1);
        checkOutput({tag, " A"}, a_A, 0);
        checkOutput({tag, " Data2Mem"}, a_Data2Mem, 0);
        checkOutput({tag, " gnts"}, {a_p0_gnt, a_p1_gnt}, 0);
        checkOutput({tag, " dones"}, {a_p0_done, a_p1_done}, 0);
        checkOutput({tag, " p0_rdata"}, a_p0_rdata, 0);
        checkOutput({tag, " p1_rdata"}, a_p1_rdata, 0);
        checkOutput({tag, " busy"}, a_busy, 0);
        checkOutput({tag, " starve_cnt"}, 32'(dutA.r_starveCnt), 0);
        checkOutput({tag, " owner"}, 32'(dutA.r_owner), 0);
    endtask

    // Scoreboard: every done pulse retires the oldest expected completion.
    always @(negedge clk) begin
        sbEntry_t e;
        if (rst_n) begin
            if (a_p0_gnt || a_p1_gnt) checkOutput("A gnt exclusive", a_p0_gnt & a_p1_gnt, 0);
            if (a_p0_done || a_p1_done) begin
                checkOutput("A done exclusive", a_p0_done & a_p1_done, 0);
                compared++;
                assert (qa.size() != 0) else begin
                    mismatched++;
                    $error("[TB] FAIL A unexpected done: observed port %0d expected none", a_p1_done);
                end
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    checkOutput("A done port", a_p1_done, e.port);
                    if (e.isRead) checkOutput("A rdata", a_p1_done ? a_p1_rdata : a_p0_rdata, e.rdata);
                end
            end
            if (b_p0_done || b_p1_done) begin
                compared++;
                assert (qb.size() != 0) else begin
                    mismatched++;
                    $error("[TB] FAIL B unexpected done: observed port %0d expected none", b_p1_done);
                end
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    checkOutput("B done port", b_p1_done, e.port);
                    if (e.isRead) checkOutput("B rdata", b_p1_done ? b_p1_rdata : b_p0_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0;
        b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;
        b_rdm = 32'h0;
        repeat (2) @(negedge clk);
        checkResetA("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Port-0 write of DEADBEEF to address 5
        applyStimulus(1, 1, 7'h05, 32'hDEADBEEF, 0, 0, 7'h0, 32'h0);
        qa.push_back('{port: 1'b0, isRead: 1'b0, rdata: 32'h0});
        @(negedge clk);
        checkOutput("wr p0_gnt", a_p0_gnt, 1);
        checkOutput("wr p1_gnt", a_p1_gnt, 0);
        checkOutput("wr CEN", a_CEN, 0);
        checkOutput("wr WEN", a_WEN, 0);
        checkOutput("wr OEN", a_OEN, 1);
        checkOutput("wr A", a_A, 7'h05);
        checkOutput("wr Data2Mem", a_Data2Mem, 32'hDEADBEEF);
        checkOutput("wr busy", a_busy, 1);
        checkOutput("wr early done", a_p0_done, 0);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("wr p0_done", a_p0_done, 1);
        checkOutput("wr p1_done", a_p1_done, 0);
        checkOutput("wr single CMD", a_CEN, 1);
        checkOutput("wr gnt cleared", a_p0_gnt, 0);
        checkOutput("wr busy low", a_busy, 0);

        // Port-0 write of 12345678 to address 0x10, then port-1 read back
        applyStimulus(1, 1, 7'h10, 32'h12345678, 0, 0, 7'h0, 32'h0);
        qa.push_back('{port: 1'b0, isRead: 1'b0, rdata: 32'h0});
        @(negedge clk);
        checkOutput("wr2 p0_gnt", a_p0_gnt, 1);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("wr2 p0_done", a_p0_done, 1);
        applyStimulus(0, 0, 7'h0, 32'h0, 1, 0, 7'h10, 32'h0);
        qa.push_back('{port: 1'b1, isRead: 1'b1, rdata: 32'h12345678});
        @(negedge clk);
        checkOutput("rd p1_gnt", a_p1_gnt, 1);
        checkOutput("rd p0_gnt", a_p0_gnt, 0);
        checkOutput("rd CMD CEN", a_CEN, 0);
        checkOutput("rd CMD WEN", a_WEN, 1);
        checkOutput("rd CMD OEN", a_OEN, 0);
        checkOutput("rd A", a_A, 7'h10);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("rd WAIT OEN", a_OEN, 0);
        checkOutput("rd WAIT CEN", a_CEN, 1);
        checkOutput("rd WAIT busy", a_busy, 1);
        checkOutput("rd WAIT no done", a_p1_done, 0);
        @(negedge clk);
        checkOutput("rd p1_done", a_p1_done, 1);
        checkOutput("rd p1_rdata", a_p1_rdata, 32'h12345678);
        checkOutput("rd p0_rdata held", a_p0_rdata, 32'h0);
        checkOutput("rd OEN released", a_OEN, 1);

        // Both ports hammering: port 1 forced after two port-0 wins, then port 1 drops out
        for (int k = 0; k < 9; k++) qa.push_back('{port: expOrder[k], isRead: 1'b0, rdata: 32'h0});
        applyStimulus(1, 1, 7'h20, 32'h20202020, 1, 1, 7'h21, 32'h21212121);
        for (int k = 0; k < 9; k++) begin
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                found = a_p0_gnt || a_p1_gnt;
            end
            compared++;
            assert (found) else begin
                mismatched++;
                $error("[TB] FAIL grant %0d timeout: observed no gnt expected gnt", k);
            end
            checkOutput($sformatf("grant %0d port", k), a_p1_gnt, expOrder[k]);
            if (k >= 6) checkOutput($sformatf("starve_cnt after grant %0d", k), 32'(dutA.r_starveCnt), 0);
            if (k == 5) a_p1_req = 1'b0;
            if (k == 8) a_p0_req = 1'b0;
        end
        @(negedge clk);

        // Port-0 read of address 5 while port 1 pulses a request for one cycle
        applyStimulus(1, 0, 7'h05, 32'h0, 0, 0, 7'h0, 32'h0);
        qa.push_back('{port: 1'b0, isRead: 1'b1, rdata: 32'hDEADBEEF});
        @(negedge clk);
        checkOutput("pulse p0_gnt", a_p0_gnt, 1);
        applyStimulus(0, 0, 7'h0, 32'h0, 1, 1, 7'h7F, 32'h00000055);
        @(negedge clk);
        checkOutput("pulse WAIT p1_gnt", a_p1_gnt, 0);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("pulse p0_done", a_p0_done, 1);
        checkOutput("pulse p0_rdata", a_p0_rdata, 32'hDEADBEEF);
        checkOutput("pulse p1_rdata held", a_p1_rdata, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("pulse no p1_gnt", a_p1_gnt, 0);
            checkOutput("pulse no access", a_CEN, 1);
            checkOutput("pulse idle", a_busy, 0);
        end
        checkOutput("pulse A untouched", a_A, 7'h05);

        // Instance B: three WAIT cycles, only the value at the final edge is kept
        b_p0_req = 1; b_p0_we = 0; b_p0_addr = 7'h33;
        qb.push_back('{port: 1'b0, isRead: 1'b1, rdata: 32'hCAFEF00D});
        @(negedge clk);
        checkOutput("B p0_gnt", b_p0_gnt, 1);
        checkOutput("B CMD OEN", b_OEN, 0);
        b_p0_req = 0;
        b_rdm = 32'hAAAA0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("B WAIT%0d busy", c + 1), b_busy, 1);
            checkOutput($sformatf("B WAIT%0d OEN", c + 1), b_OEN, 0);
            checkOutput($sformatf("B WAIT%0d CEN", c + 1), b_CEN, 1);
            checkOutput($sformatf("B WAIT%0d no done", c + 1), b_p0_done, 0);
            b_rdm = (c == 2) ? 32'hCAFEF00D : 32'hAAAA0002 + 32'(c);
        end
        @(negedge clk);
        checkOutput("B p0_done", b_p0_done, 1);
        checkOutput("B p0_rdata", b_p0_rdata, 32'hCAFEF00D);
        checkOutput("B OEN released", b_OEN, 1);
        checkOutput("B busy low", b_busy, 0);
        b_rdm = 32'hFFFFFFFF;
        @(negedge clk);
        checkOutput("B rdata holds", b_p0_rdata, 32'hCAFEF00D);

        // Reset during WAIT abandons the read; a later write still completes
        applyStimulus(1, 0, 7'h10, 32'h0, 0, 0, 7'h0, 32'h0);
        qa.push_back('{port: 1'b0, isRead: 1'b1, rdata: 32'h12345678});
        @(negedge clk);
        checkOutput("rst rd p0_gnt", a_p0_gnt, 1);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst rd WAIT busy", a_busy, 1);
        checkOutput("rst rd WAIT OEN", a_OEN, 0);
        #2 rst_n = 1'b0;
        #1 checkResetA("mid-WAIT reset");
        void'(qa.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post-reset no done", {a_p0_done, a_p1_done}, 0);
            checkOutput("post-reset idle", a_busy, 0);
        end
        applyStimulus(1, 1, 7'h03, 32'h0BADF00D, 0, 0, 7'h0, 32'h0);
        qa.push_back('{port: 1'b0, isRead: 1'b0, rdata: 32'h0});
        @(negedge clk);
        checkOutput("post-reset wr gnt", a_p0_gnt, 1);
        checkOutput("post-reset wr A", a_A, 7'h03);
        checkOutput("post-reset wr WEN", a_WEN, 0);
        applyStimulus(0, 0, 7'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        @(negedge clk);
        checkOutput("post-reset wr done", a_p0_done, 1);
        repeat (2) @(negedge clk);

        checkOutput("A scoreboard drained", qa.size(), 0);
        checkOutput("B scoreboard drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
